// File: rtl/omsp_dbg_cmd_seq.sv
// Debug command sequencer: turns UART byte frames into debug register bus accesses
// and streams read data back to the UART transmitter, including memory burst data phases.
module omsp_dbg_cmd_seq #(
  parameter logic [7:0]  SYNC_CHAR     = 8'h80,
  parameter logic [5:0]  MEM_DATA_ADDR = 6'h06,
  parameter logic [15:0] RX_TIMEOUT    = 16'hFFFF
) (
  input  logic        dbg_clk,
  input  logic        dbg_rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [5:0]  dbg_addr,
  output logic [15:0] dbg_din,
  output logic        dbg_wr,
  output logic        dbg_rd,
  output logic        dbg_bw,
  input  logic [15:0] dbg_dout,
  input  logic        mem_burst,
  input  logic        mem_burst_rd,
  output logic        synced
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    S_SYNC, S_CMD, S_RX_LO, S_RX_HI, S_WR, S_RD, S_TX_LO, S_TX_HI, S_BURST_CHK
  } state_e;

  state_e state_q, state_d;

  logic             synced_q, synced_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [5:0]       addr_q, addr_d;
  logic [15:0]      din_q, din_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             bw_q, bw_d;
  logic [7:0]       rdata_hi_q, rdata_hi_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic tx_acc;
  logic tmo_run;
  logic tmo_hit;

  assign tx_acc  = tx_valid_q & tx_ready;
  // Idle timer only runs while waiting for bytes that complete a frame.
  assign tmo_run = (state_q == S_RX_LO) || (state_q == S_RX_HI) ||
                   ((state_q == S_CMD) && mem_burst);
  assign tmo_hit = tmo_run && !rx_valid && (RX_TIMEOUT != CNT_W'(0)) &&
                   (tmo_cnt_q == RX_TIMEOUT);

  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) state_q <= S_SYNC;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_err) begin
      state_d = S_SYNC;
    end else begin
      case (state_q)
        S_SYNC:      if (rx_valid && (rx_data == SYNC_CHAR)) state_d = S_CMD;
        S_CMD:       if (rx_valid) state_d = rx_data[7] ? S_RX_LO : S_RD;
        S_RX_LO: begin
          if (rx_valid)     state_d = bw_q ? S_WR : S_RX_HI;
          else if (tmo_hit) state_d = S_CMD;
        end
        S_RX_HI: begin
          if (rx_valid)     state_d = S_WR;
          else if (tmo_hit) state_d = S_CMD;
        end
        S_WR:        state_d = S_BURST_CHK;
        S_RD:        state_d = S_TX_LO;
        S_TX_LO:     if (tx_acc) state_d = bw_q ? S_BURST_CHK : S_TX_HI;
        S_TX_HI:     if (tx_acc) state_d = S_BURST_CHK;
        S_BURST_CHK: begin
          if (!mem_burst)       state_d = S_CMD;
          else if (mem_burst_rd) state_d = S_RD;
          else                   state_d = S_RX_LO;
        end
        default:     state_d = S_SYNC;
      endcase
    end
  end

  // Strobes and tx_valid are registered so they line up with the state they belong to.
  always_comb begin
    synced_d   = synced_q;
    tx_valid_d = (state_d == S_TX_LO) || (state_d == S_TX_HI);
    tx_data_d  = tx_data_q;
    addr_d     = addr_q;
    bw_d       = bw_q;
    din_d      = din_q;
    wr_d       = (state_d == S_WR);
    rd_d       = (state_d == S_RD);
    rdata_hi_d = rdata_hi_q;
    tmo_cnt_d  = tmo_cnt_q;

    if (!tmo_run || rx_valid)        tmo_cnt_d = '0;
    else if (tmo_cnt_q != '1)        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);

    if (rx_err) begin
      synced_d = 1'b0;
    end else begin
      case (state_q)
        S_SYNC:  if (state_d == S_CMD) synced_d = 1'b1;
        S_CMD: begin
          if (rx_valid) begin
            addr_d = rx_data[5:0];
            bw_d   = rx_data[6];
          end
        end
        S_RX_LO: if (rx_valid) din_d = {8'h00, rx_data};
        S_RX_HI: if (rx_valid) din_d[15:8] = rx_data;
        S_RD: begin
          tx_data_d  = dbg_dout[7:0];
          rdata_hi_d = dbg_dout[15:8];
        end
        S_TX_LO: if (tx_acc && !bw_q) tx_data_d = rdata_hi_q;
        S_BURST_CHK: if (mem_burst) addr_d = MEM_DATA_ADDR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      synced_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      addr_q     <= '0;
      bw_q       <= 1'b0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rdata_hi_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      synced_q   <= synced_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      addr_q     <= addr_d;
      bw_q       <= bw_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rdata_hi_q <= rdata_hi_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign synced   = synced_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign dbg_addr = addr_q;
  assign dbg_bw   = bw_q;
  assign dbg_din  = din_q;
  assign dbg_wr   = wr_q;
  assign dbg_rd   = rd_q;

endmodule

// File: tb/tb_omsp_dbg_cmd_seq.sv
// Bench for omsp_dbg_cmd_seq: frame vector table plus scoreboard of expected bus accesses
// and transmitted bytes, with hand-written burst, timeout, error and reset sequences.
module tb_omsp_dbg_cmd_seq;

  logic        dbg_clk = 1'b0;
  logic        dbg_rst;
  logic        rx_valid, rx_err, tx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [5:0]  dbg_addr;
  logic [15:0] dbg_din;
  logic        dbg_wr, dbg_rd, dbg_bw;
  logic [15:0] dbg_dout;
  logic        mem_burst, mem_burst_rd;
  logic        synced;

  always #5 dbg_clk = ~dbg_clk;

  omsp_dbg_cmd_seq #(.RX_TIMEOUT(16'd20)) dut (
    .dbg_clk(dbg_clk), .dbg_rst(dbg_rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .dbg_addr(dbg_addr), .dbg_din(dbg_din), .dbg_wr(dbg_wr), .dbg_rd(dbg_rd),
    .dbg_bw(dbg_bw), .dbg_dout(dbg_dout),
    .mem_burst(mem_burst), .mem_burst_rd(mem_burst_rd), .synced(synced)
  );

  typedef struct packed {
    logic        is_rd;
    logic [5:0]  addr;
    logic        bw;
    logic [15:0] din;
  } bus_t;

  typedef struct packed {
    logic [7:0]  b0, b1, b2;
    logic [1:0]  nb;
    logic [15:0] dout;
    logic        is_rd;
    logic [5:0]  addr;
    logic        bw;
    logic [15:0] din;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bus_t exp_bus[$];
  logic [7:0] exp_tx[$];
  logic tx_rand;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dbg_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_bus(input logic is_rd, input logic [5:0] a, input logic bw, input logic [15:0] d);
    bus_t e;
    e.is_rd = is_rd; e.addr = a; e.bw = bw; e.din = d;
    exp_bus.push_back(e);
  endtask

  task automatic drain(input string nm);
    int cyc = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0) && cyc < 200) begin
      tick();
      cyc++;
    end
    check(nm, 32'(exp_bus.size() + exp_tx.size()), 32'd0);
    idle(3);
  endtask

  task automatic wait_tx_valid(input string nm);
    int cyc = 0;
    while (!tx_valid && cyc < 20) begin
      @(negedge dbg_clk);
      cyc++;
    end
    check(nm, 32'(tx_valid), 32'd1);
  endtask

  initial begin
    vecs[0] = '{b0:8'hC3, b1:8'h5A, b2:8'h00, nb:2'd2, dout:16'h0000, is_rd:1'b0, addr:6'h03, bw:1'b1, din:16'h005A};
    vecs[1] = '{b0:8'h85, b1:8'h34, b2:8'h12, nb:2'd3, dout:16'h0000, is_rd:1'b0, addr:6'h05, bw:1'b0, din:16'h1234};
    vecs[2] = '{b0:8'h02, b1:8'h00, b2:8'h00, nb:2'd1, dout:16'hBEEF, is_rd:1'b1, addr:6'h02, bw:1'b0, din:16'h0000};
    vecs[3] = '{b0:8'h41, b1:8'h00, b2:8'h00, nb:2'd1, dout:16'h12A7, is_rd:1'b1, addr:6'h01, bw:1'b1, din:16'h0000};
    vecs[4] = '{b0:8'hFF, b1:8'h9C, b2:8'h00, nb:2'd2, dout:16'h0000, is_rd:1'b0, addr:6'h3F, bw:1'b1, din:16'h009C};
    vecs[5] = '{b0:8'hBF, b1:8'h55, b2:8'hAA, nb:2'd3, dout:16'h0000, is_rd:1'b0, addr:6'h3F, bw:1'b0, din:16'hAA55};
    vecs[6] = '{b0:8'h3F, b1:8'h00, b2:8'h00, nb:2'd1, dout:16'h0001, is_rd:1'b1, addr:6'h3F, bw:1'b0, din:16'h0000};
    vecs[7] = '{b0:8'h80, b1:8'h77, b2:8'h66, nb:2'd3, dout:16'h0000, is_rd:1'b0, addr:6'h00, bw:1'b0, din:16'h6677};

    dbg_rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0; tx_ready = 1'b0;
    dbg_dout = '0; mem_burst = 1'b0; mem_burst_rd = 1'b0; tx_rand = 1'b1;

    @(negedge dbg_clk);
    check("rst_synced", 32'(synced), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_strobes", 32'({dbg_wr, dbg_rd}), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_addr_bw", 32'({dbg_addr, dbg_bw}), 32'd0);
    check("rst_din", 32'(dbg_din), 32'd0);
    tick();
    dbg_rst = 1'b0;
    tick();

    fork
      begin : monitor
        logic pv, pr;
        logic [7:0] pd;
        bus_t e;
        pv = 1'b0; pr = 1'b0; pd = '0;
        forever begin
          @(negedge dbg_clk);
          if (dbg_rst) begin
            pv = 1'b0;
          end else begin
            if (dbg_wr || dbg_rd) begin
              if (exp_bus.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL bus_unexpected: got wr=%0b rd=%0b addr=%0h required no strobe", dbg_wr, dbg_rd, dbg_addr);
              end else begin
                e = exp_bus.pop_front();
                check("bus_kind", 32'({dbg_wr, dbg_rd}), 32'({~e.is_rd, e.is_rd}));
                check("bus_addr", 32'(dbg_addr), 32'(e.addr));
                check("bus_bw", 32'(dbg_bw), 32'(e.bw));
                if (!e.is_rd) check("bus_din", 32'(dbg_din), 32'(e.din));
              end
            end
            if (pv && !pr && tx_valid) check("tx_stable", 32'(tx_data), 32'(pd));
            if (tx_valid && tx_ready) begin
              if (exp_tx.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL tx_unexpected: got %0h required no byte", tx_data);
              end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
              end
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
          end
        end
      end
      begin : ready_gen
        forever begin
          tick();
          if (tx_rand) tx_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none

    // Non-sync bytes are ignored until the sync character arrives.
    send_byte(8'h55);
    @(negedge dbg_clk); check("sync_ignore", 32'(synced), 32'd0); tick();
    send_byte(8'h80);
    @(negedge dbg_clk); check("sync_lock", 32'(synced), 32'd1); tick();

    for (int i = 0; i < 8; i++) begin
      dbg_dout = vecs[i].dout;
      push_bus(vecs[i].is_rd, vecs[i].addr, vecs[i].bw, vecs[i].din);
      if (vecs[i].is_rd) begin
        exp_tx.push_back(vecs[i].dout[7:0]);
        if (!vecs[i].bw) exp_tx.push_back(vecs[i].dout[15:8]);
      end
      for (int k = 0; k < int'(vecs[i].nb); k++)
        send_byte(k == 0 ? vecs[i].b0 : (k == 1 ? vecs[i].b1 : vecs[i].b2));
      @(negedge dbg_clk);
      check($sformatf("vec%0d_latency", i), 32'({dbg_wr, dbg_rd}), 32'({~vecs[i].is_rd, vecs[i].is_rd}));
      tick();
      @(negedge dbg_clk);
      check($sformatf("vec%0d_single", i), 32'({dbg_wr, dbg_rd}), 32'd0);
      tick();
      drain($sformatf("vec%0d_drain", i));
    end

    // Write burst: three data words to the memory data register, then back to CMD.
    push_bus(1'b0, 6'h06, 1'b0, 16'h2211);
    push_bus(1'b0, 6'h06, 1'b0, 16'h4433);
    push_bus(1'b0, 6'h06, 1'b0, 16'h6655);
    send_byte(8'h86);
    mem_burst = 1'b1; mem_burst_rd = 1'b0;
    send_byte(8'h11); send_byte(8'h22);
    idle(2);
    send_byte(8'h33); send_byte(8'h44);
    idle(2);
    send_byte(8'h55);
    mem_burst = 1'b0;
    send_byte(8'h66);
    drain("wburst_drain");
    push_bus(1'b0, 6'h03, 1'b1, 16'h005A);
    send_byte(8'hC3); send_byte(8'h5A);
    drain("wburst_after_cmd");

    // Read burst: second data phase must target the memory data register.
    dbg_dout = 16'h12A7;
    push_bus(1'b1, 6'h01, 1'b1, 16'h0000); exp_tx.push_back(8'hA7);
    push_bus(1'b1, 6'h06, 1'b1, 16'h0000); exp_tx.push_back(8'hA7);
    send_byte(8'h41);
    mem_burst = 1'b1; mem_burst_rd = 1'b1;
    begin
      int cyc = 0;
      while (!(dbg_rd && dbg_addr == 6'h06) && cyc < 100) begin
        @(negedge dbg_clk);
        cyc++;
      end
      check("rburst_second_rd", 32'(cyc < 100), 32'd1);
    end
    tick();
    mem_burst = 1'b0;
    drain("rburst_drain");

    // Short gaps below the timeout keep the frame alive.
    push_bus(1'b0, 6'h05, 1'b0, 16'h1234);
    send_byte(8'h85); idle(10); send_byte(8'h34); idle(15); send_byte(8'h12);
    drain("gap_drain");

    // Long gap aborts the partial frame; the next byte is a fresh command.
    send_byte(8'h81);
    idle(30);
    push_bus(1'b0, 6'h03, 1'b1, 16'h005A);
    send_byte(8'hC3); send_byte(8'h5A);
    drain("timeout_drain");

    // rx_err together with the final data byte: error wins, no write.
    send_byte(8'h85); send_byte(8'h34);
    rx_data = 8'h12; rx_valid = 1'b1; rx_err = 1'b1;
    tick();
    rx_valid = 1'b0; rx_err = 1'b0;
    @(negedge dbg_clk); check("err_valid_synced", 32'(synced), 32'd0); tick();
    idle(3);
    send_byte(8'h80);
    @(negedge dbg_clk); check("resync1", 32'(synced), 32'd1); tick();

    // rx_err alone in RX_HI; following data byte must be ignored in SYNC.
    send_byte(8'h85); send_byte(8'h34);
    rx_err = 1'b1; tick(); rx_err = 1'b0;
    @(negedge dbg_clk); check("err_rxhi_synced", 32'(synced), 32'd0); tick();
    send_byte(8'h12);
    idle(3);
    send_byte(8'h80);
    push_bus(1'b0, 6'h03, 1'b1, 16'h005A);
    send_byte(8'hC3); send_byte(8'h5A);
    drain("err_rxhi_recover");

    // rx_err while a tx byte is pending drops tx_valid.
    tx_rand = 1'b0; tx_ready = 1'b0;
    dbg_dout = 16'hBEEF;
    push_bus(1'b1, 6'h02, 1'b0, 16'h0000);
    send_byte(8'h02);
    wait_tx_valid("err_tx_valid_up");
    tick();
    rx_err = 1'b1; tick(); rx_err = 1'b0;
    @(negedge dbg_clk);
    check("err_tx_drop", 32'({tx_valid, synced}), 32'd0);
    tick();
    send_byte(8'h80);

    // Reset while stalled in TX_LO: data held, then everything cleared at once.
    push_bus(1'b1, 6'h02, 1'b0, 16'h0000);
    exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
    send_byte(8'h02);
    wait_tx_valid("rst_tx_valid_up");
    check("tx_lo_data", 32'(tx_data), 32'hEF);
    repeat (3) begin
      @(negedge dbg_clk);
      check("tx_stall_hold", 32'({tx_valid, tx_data}), 32'h1EF);
    end
    #2 dbg_rst = 1'b1;
    #1;
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_synced", 32'(synced), 32'd0);
    check("rst_mid_strobes", 32'({dbg_wr, dbg_rd}), 32'd0);
    exp_tx.delete();
    exp_bus.delete();
    tick();
    dbg_rst = 1'b0;
    tx_ready = 1'b1;
    idle(3);
    @(negedge dbg_clk);
    check("post_rst_idle", 32'({tx_valid, synced}), 32'd0);
    tick();
    tx_rand = 1'b1;
    send_byte(8'h80);
    push_bus(1'b0, 6'h05, 1'b0, 16'h1234);
    send_byte(8'h85); send_byte(8'h34); send_byte(8'h12);
    drain("post_rst_frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
